sysid_boot_checker: RTL and testbench



---
 rtl/sysid_boot_checker.sv | 181 ++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker
// Avalon-MM read master that fetches the system-ID word (address 0) and the
// build timestamp (address 1), compares them with the expected build and
// holds a pass/fail verdict so boot logic can gate software release.
// Each read is bounded by a timeout. A timeout or a mismatch triggers a full
// retry, delay included, until the retry budget is exhausted.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1494161508,
    parameter int unsigned START_DELAY        = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        restart,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        check_done,
    output logic        check_pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout_err,
    output logic [3:0]  retry_count
);

    localparam logic [2:0] ST_DELAY   = 3'd0;
    localparam logic [2:0] ST_REQ_ID  = 3'd1;
    localparam logic [2:0] ST_WAIT_ID = 3'd2;
    localparam logic [2:0] ST_REQ_TS  = 3'd3;
    localparam logic [2:0] ST_WAIT_TS = 3'd4;
    localparam logic [2:0] ST_CHECK   = 3'd5;
    localparam logic [2:0] ST_PASS    = 3'd6;
    localparam logic [2:0] ST_FAIL    = 3'd7;

    // Terminal counts are one less than the configured length because the
    // counters start from zero on the first cycle of the phase.
    localparam logic [7:0]  LP_DELAY_LAST   = 8'(START_DELAY - 1);
    localparam logic [15:0] LP_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LP_MAX_RETRIES  = 4'(MAX_RETRIES);

    logic [2:0]  r_state;
    logic [7:0]  r_delayCnt;
    logic [15:0] r_timeoutCnt;
    logic [31:0] r_idValue;
    logic [31:0] r_tsValue;
    logic        r_idMismatch;
    logic        r_tsMismatch;
    logic        r_timeoutErr;
    logic [3:0]  r_retryCount;

    logic        w_inReq;
    logic        w_accepted;
    logic        w_timeoutHit;
    logic        w_canRetry;
    logic        w_idBad;
    logic        w_tsBad;
    logic [2:0]  w_retryState;

    assign w_inReq      = (r_state == ST_REQ_ID) || (r_state == ST_REQ_TS);
    assign w_accepted   = w_inReq && !avm_waitrequest;
    assign w_timeoutHit = (r_timeoutCnt == LP_TIMEOUT_LAST);
    assign w_canRetry   = (r_retryCount < LP_MAX_RETRIES);
    assign w_idBad      = (r_idValue != EXPECTED_ID);
    assign w_tsBad      = (r_tsValue != EXPECTED_TIMESTAMP);
    assign w_retryState = w_canRetry ? ST_DELAY : ST_FAIL;

    // The request is decoded from state, so leaving a request state for any
    // reason drops avm_read on the following cycle.
    assign avm_read        = w_inReq;
    assign avm_address     = (r_state == ST_REQ_TS);
    assign id_value        = r_idValue;
    assign timestamp_value = r_tsValue;
    assign check_done      = (r_state == ST_PASS) || (r_state == ST_FAIL);
    assign check_pass      = (r_state == ST_PASS);
    assign id_mismatch     = r_idMismatch;
    assign ts_mismatch     = r_tsMismatch;
    assign timeout_err     = r_timeoutErr;
    assign retry_count     = r_retryCount;

    // Sequencer: restart outranks everything except reset; readdatavalid is
    // only honoured while the matching read is outstanding (or accepted in
    // the same cycle), so stale responses after an abort are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_DELAY;
            r_delayCnt   <= '0;
            r_timeoutCnt <= '0;
            r_idValue    <= '0;
            r_tsValue    <= '0;
            r_idMismatch <= 1'b0;
            r_tsMismatch <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_retryCount <= '0;
        end else if (restart) begin
            r_state      <= ST_DELAY;
            r_delayCnt   <= '0;
            r_timeoutCnt <= '0;
            r_idMismatch <= 1'b0;
            r_tsMismatch <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_retryCount <= '0;
        end else begin
            case (r_state)
                ST_DELAY: begin
                    if (r_delayCnt == LP_DELAY_LAST) begin
                        r_state      <= ST_REQ_ID;
                        r_delayCnt   <= '0;
                        r_timeoutCnt <= '0;
                        r_idMismatch <= 1'b0;
                        r_tsMismatch <= 1'b0;
                        r_timeoutErr <= 1'b0;
                    end else begin
                        r_delayCnt <= r_delayCnt + 8'd1;
                    end
                end
                ST_REQ_ID, ST_REQ_TS: begin
                    r_timeoutCnt <= r_timeoutCnt + 16'd1;
                    if (w_accepted && avm_readdatavalid) begin
                        r_timeoutCnt <= '0;
                        if (r_state == ST_REQ_ID) begin
                            r_idValue <= avm_readdata;
                            r_state   <= ST_REQ_TS;
                        end else begin
                            r_tsValue <= avm_readdata;
                            r_state   <= ST_CHECK;
                        end
                    end else if (w_timeoutHit) begin
                        r_timeoutErr <= 1'b1;
                        r_state      <= w_retryState;
                        if (w_canRetry) begin
                            r_retryCount <= r_retryCount + 4'd1;
                        end
                    end else if (w_accepted) begin
                        r_state <= (r_state == ST_REQ_ID) ? ST_WAIT_ID : ST_WAIT_TS;
                    end
                end
                ST_WAIT_ID, ST_WAIT_TS: begin
                    r_timeoutCnt <= r_timeoutCnt + 16'd1;
                    if (avm_readdatavalid) begin
                        r_timeoutCnt <= '0;
                        if (r_state == ST_WAIT_ID) begin
                            r_idValue <= avm_readdata;
                            r_state   <= ST_REQ_TS;
                        end else begin
                            r_tsValue <= avm_readdata;
                            r_state   <= ST_CHECK;
                        end
                    end else if (w_timeoutHit) begin
                        r_timeoutErr <= 1'b1;
                        r_state      <= w_retryState;
                        if (w_canRetry) begin
                            r_retryCount <= r_retryCount + 4'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    r_idMismatch <= w_idBad;
                    r_tsMismatch <= w_tsBad;
                    if (!w_idBad && !w_tsBad) begin
                        r_state <= ST_PASS;
                    end else begin
                        r_state <= w_retryState;
                        if (w_canRetry) begin
                            r_retryCount <= r_retryCount + 4'd1;
                        end
                    end
                end
                ST_PASS: r_state <= ST_PASS;
                ST_FAIL: r_state <= ST_FAIL;
                default: r_state <= ST_DELAY;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker
// Directed bench for sysid_boot_checker. A behavioural Avalon slave with
// configurable stall, latency and data answers the DUT; expected verdicts
// are queued when each scenario is launched and compared once check_done
// rises.
module tb_sysid_boot_checker;

    localparam int          START_DELAY    = 16;
    localparam int          TIMEOUT_CYCLES = 20;
    localparam int          MAX_RETRIES    = 3;
    localparam logic [31:0] EXP_ID         = 32'd0;
    localparam logic [31:0] EXP_TS         = 32'h590F7464;
    localparam logic [31:0] BAD_ID         = 32'h12345678;

    logic        clock;
    logic        reset;
    logic        restart;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [31:0] id_value;
    logic [31:0] timestamp_value;
    logic        check_done;
    logic        check_pass;
    logic        id_mismatch;
    logic        ts_mismatch;
    logic        timeout_err;
    logic [3:0]  retry_count;

    typedef struct {
        int          testNum;
        logic [31:0] idVal;
        logic [31:0] tsVal;
        logic        pass;
        logic        idMis;
        logic        tsMis;
        logic        tmo;
        logic [3:0]  retries;
    } expect_t;

    expect_t scoreQ[$];

    int passCount  = 0;
    int checkCount = 0;

    // Slave configuration and bookkeeping
    int          waitCycles = 0;
    int          latency    = 0;
    bit          noValid    = 1'b0;
    int          idWrongLeft = 0;
    logic [31:0] idData = EXP_ID;
    logic [31:0] tsData = EXP_TS;
    int          acceptCount [2];
    int          stallCnt = 0;
    logic        stallAddr = 1'b0;
    int          stallViolations = 0;
    bit          outstanding = 1'b0;
    int          latLeft = 0;
    logic [31:0] pendData = '0;
    logic [31:0] respData = '0;
    bit          injectStray = 1'b0;

    sysid_boot_checker #(
        .EXPECTED_ID       (EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .START_DELAY       (START_DELAY),
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES),
        .MAX_RETRIES       (MAX_RETRIES)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .restart          (restart),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .id_value         (id_value),
        .timestamp_value  (timestamp_value),
        .check_done       (check_done),
        .check_pass       (check_pass),
        .id_mismatch      (id_mismatch),
        .ts_mismatch      (ts_mismatch),
        .timeout_err      (timeout_err),
        .retry_count      (retry_count)
    );

    // Free-running 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural sysid slave, updated on the falling edge so the DUT sees
    // stable inputs at the rising edge. Response data is fixed at acceptance.
    always @(negedge clock) begin
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        if (outstanding) begin
            latLeft = latLeft - 1;
            if (latLeft <= 0) begin
                outstanding       = 1'b0;
                avm_readdatavalid = 1'b1;
                avm_readdata      = pendData;
            end
        end
        if (injectStray) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hBADBAD00;
            injectStray       = 1'b0;
        end
        if (avm_read === 1'b1 && !outstanding) begin
            if (stallCnt > 0 && avm_address !== stallAddr) stallViolations++;
            if (stallCnt < waitCycles) begin
                if (stallCnt == 0) stallAddr = avm_address;
                avm_waitrequest = 1'b1;
                stallCnt++;
            end else begin
                stallCnt = 0;
                acceptCount[avm_address]++;
                if (avm_address) begin
                    respData = tsData;
                end else if (idWrongLeft > 0) begin
                    respData = BAD_ID;
                    idWrongLeft--;
                end else begin
                    respData = idData;
                end
                if (!noValid) begin
                    if (latency == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = respData;
                    end else begin
                        outstanding = 1'b1;
                        latLeft     = latency;
                        pendData    = respData;
                    end
                end
            end
        end else if (avm_read !== 1'b1) begin
            if (stallCnt > 0) stallViolations++;
            stallCnt = 0;
        end
    end

    // One comparison: counts, and reports on mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    task automatic pushExpect(input int t, input logic [31:0] idv, input logic [31:0] tsv,
                              input logic p, input logic im, input logic tm,
                              input logic to, input logic [3:0] r);
        expect_t e;
        e.testNum = t;
        e.idVal   = idv;
        e.tsVal   = tsv;
        e.pass    = p;
        e.idMis   = im;
        e.tsMis   = tm;
        e.tmo     = to;
        e.retries = r;
        scoreQ.push_back(e);
    endtask

    // Launch a new check sequence with a one-cycle restart pulse
    task automatic applyStimulus();
        acceptCount[0]  = 0;
        acceptCount[1]  = 0;
        stallViolations = 0;
        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while (check_done !== 1'b1 && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    // Wait for a verdict then compare it against the oldest queued one
    task automatic popCompare(input int budget);
        int     cycles;
        expect_t e;
        string  p;
        waitDone(budget, cycles);
        checkOutput("doneReached", {31'd0, check_done}, 32'd1);
        checkOutput("scoreQueueNotEmpty", {31'd0, scoreQ.size() > 0}, 32'd1);
        if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            p = $sformatf("t%0d.", e.testNum);
            checkOutput({p, "id_value"}, id_value, e.idVal);
            checkOutput({p, "timestamp_value"}, timestamp_value, e.tsVal);
            checkOutput({p, "check_pass"}, {31'd0, check_pass}, {31'd0, e.pass});
            checkOutput({p, "id_mismatch"}, {31'd0, id_mismatch}, {31'd0, e.idMis});
            checkOutput({p, "ts_mismatch"}, {31'd0, ts_mismatch}, {31'd0, e.tsMis});
            checkOutput({p, "timeout_err"}, {31'd0, timeout_err}, {31'd0, e.tmo});
            checkOutput({p, "retry_count"}, {28'd0, retry_count}, {28'd0, e.retries});
            checkOutput({p, "avm_read_idle"}, {31'd0, avm_read}, 32'd0);
        end
    endtask

    task automatic waitReadAddr(input logic addr, input int budget, input string tag);
        int n;
        n = 0;
        while (!(avm_read === 1'b1 && avm_address === addr) && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, {31'd0, avm_read}, 32'd1);
    endtask

    initial begin
        int cycles;
        int n;
        reset   = 1'b1;
        restart = 1'b0;
        acceptCount[0] = 0;
        acceptCount[1] = 0;
        repeat (2) @(negedge clock);

        $display("[TB] reset state");
        checkOutput("rst.avm_read", {31'd0, avm_read}, 32'd0);
        checkOutput("rst.id_value", id_value, 32'd0);
        checkOutput("rst.timestamp_value", timestamp_value, 32'd0);
        checkOutput("rst.flags", {26'd0, check_done, check_pass, id_mismatch,
                                  ts_mismatch, timeout_err, avm_address}, 32'd0);
        checkOutput("rst.retry_count", {28'd0, retry_count}, 32'd0);

        $display("[TB] test 1: zero-latency slave");
        pushExpect(1, EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        waitDone(START_DELAY + 5, cycles);
        checkOutput("t1.doneWithinBudget", {31'd0, check_done}, 32'd1);
        popCompare(1);

        $display("[TB] test 2: waitrequest stall and latency 2");
        waitCycles = 3;
        latency    = 2;
        pushExpect(2, EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus();
        popCompare(200);
        checkOutput("t2.idReads", acceptCount[0], 32'd1);
        checkOutput("t2.tsReads", acceptCount[1], 32'd1);
        checkOutput("t2.stallStable", stallViolations, 32'd0);

        $display("[TB] test 3: persistent timestamp mismatch");
        waitCycles = 0;
        latency    = 1;
        tsData     = 32'h590F7465;
        pushExpect(3, EXP_ID, 32'h590F7465, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        applyStimulus();
        popCompare(400);
        checkOutput("t3.idReads", acceptCount[0], 32'd4);
        checkOutput("t3.tsReads", acceptCount[1], 32'd4);

        $display("[TB] test 4: readdatavalid never arrives");
        tsData  = EXP_TS;
        noValid = 1'b1;
        pushExpect(4, EXP_ID, 32'h590F7465, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        applyStimulus();
        n = 0;
        while (timeout_err !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t4.firstTimeout", {31'd0, timeout_err}, 32'd1);
        checkOutput("t4.readDroppedAfterTimeout", {31'd0, avm_read}, 32'd0);
        checkOutput("t4.retryAfterFirst", {28'd0, retry_count}, 32'd1);
        popCompare(400);
        checkOutput("t4.idReads", acceptCount[0], 32'd4);
        checkOutput("t4.tsReads", acceptCount[1], 32'd0);

        $display("[TB] test 5: wrong ID once, then correct");
        noValid     = 1'b0;
        waitCycles  = 1;
        latency     = 0;
        idWrongLeft = 1;
        pushExpect(5, EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        applyStimulus();
        n = 0;
        while (id_mismatch !== 1'b1 && n < 80) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t5.firstIdMismatch", {31'd0, id_mismatch}, 32'd1);
        checkOutput("t5.retryAfterMismatch", {28'd0, retry_count}, 32'd1);
        checkOutput("t5.notDoneYet", {31'd0, check_done}, 32'd0);
        popCompare(100);

        $display("[TB] test 6: restart in WAIT_TS, reset in REQ_ID");
        waitCycles = 0;
        latency    = 3;
        tsData     = 32'hBAD0BAD0;
        applyStimulus();
        waitReadAddr(1'b1, 80, "t6.tsReadSeen");
        tsData = EXP_TS;
        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        checkOutput("t6.restartReadDropped", {31'd0, avm_read}, 32'd0);
        checkOutput("t6.restartCleared", {27'd0, check_done, check_pass, id_mismatch,
                                          ts_mismatch, timeout_err}, 32'd0);
        repeat (4) @(negedge clock);
        checkOutput("t6.lateValidIgnored", timestamp_value, EXP_TS);
        checkOutput("t6.idRetained", id_value, EXP_ID);
        waitCycles = 3;
        waitReadAddr(1'b0, 40, "t6.idReadSeen");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("t6.resetReadDropped", {31'd0, avm_read}, 32'd0);
        checkOutput("t6.resetTsCleared", timestamp_value, 32'd0);
        injectStray = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("t6.strayIdIgnored", id_value, 32'd0);
        checkOutput("t6.strayTsIgnored", timestamp_value, 32'd0);
        pushExpect(6, EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        popCompare(120);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
